// File: rtl/fsm_stream_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fsm_arb_pkg
// Shared definitions for the stream arbiter slice:
//   arb_state_e  - arbiter sequencer states (2-bit encoding)
//   idx_width()  - width of a requester index, at least 1 bit
//   cnt_width()  - width of the per-grant bit counter, at least 1 bit
// -----------------------------------------------------------------------------
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    RUN   = 2'b10,
    DONE  = 2'b11
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/fsm_stream_arbiter_if.sv
// -----------------------------------------------------------------------------
// fsm_stream_arbiter_if
// Requester-side bundle of the stream arbiter.
//   req   - per-requester request / bit-valid while granted
//   data  - per-requester serial bit
//   grant - one-hot current owner
//   hit   - per-requester detector hit pulse
// master: the stream sources; slave: the arbiter.
// -----------------------------------------------------------------------------
interface fsm_stream_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] data;
  logic [N-1:0] grant;
  logic [N-1:0] hit;

  modport master (
    output req,
    output data,
    input  grant,
    input  hit
  );

  modport slave (
    input  req,
    input  data,
    output grant,
    output hit
  );
endinterface

// File: rtl/fsm_stream_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
//   req    in  N  request vector
//   last   in  W  index of the previous owner
//   winner out W  first set bit scanning last+1, last+2, ... modulo N
//   any    out 1  at least one request is set
// winner holds `last` when nothing is requested.
// -----------------------------------------------------------------------------
module rr_pick
  import fsm_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any
);

  int unsigned idx;
  logic [W-1:0] pos;

  // Scan from the farthest offset to the nearest so the nearest set bit
  // is the last one written and therefore wins.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = 0;
    pos    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(last) + (N - k);
      if (idx >= N) begin
        idx = idx - N;
      end
      pos = W'(idx);
      if (req[pos]) begin
        winner = pos;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsm_stream_arbiter.sv
// -----------------------------------------------------------------------------
// fsm_stream_arbiter
// Shares one serial sequence-detector FSM between N bit-stream requesters.
// A requester is granted in round-robin order, the detector is cleared for
// one cycle, then up to BURST bits of the owner's stream are forwarded and
// the detector's y output is steered back to the owner as a hit pulse.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset_n    in   synchronous active-low reset
//   bus        slave modport: req, data in; grant, hit out
//   owner      out  index of the current or most recent owner
//   fsm_clr_n  out  active-low synchronous clear for the detector
//   fsm_enable out  detector enable (owner's req while running)
//   fsm_a      out  detector input bit (owner's data while running)
//   fsm_y      in   detector output
// -----------------------------------------------------------------------------
module fsm_stream_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  fsm_stream_arbiter_if.slave  bus,
  output logic [$clog2(N)-1:0] owner,
  output logic                 fsm_clr_n,
  output logic                 fsm_enable,
  output logic                 fsm_a,
  input  logic                 fsm_y
);

  localparam int unsigned OW = $clog2(N);
  localparam int unsigned CW = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
  localparam logic [OW-1:0] LAST_INIT = OW'(N - 1);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clr_n_q;

  logic [OW-1:0] win;
  logic          any;
  logic          owner_req;
  logic          owner_data;
  logic [N-1:0]  owner_onehot;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (win),
    .any    (any)
  );

  assign owner_req  = bus.req[owner_q];
  assign owner_data = bus.data[owner_q];
  assign owner      = owner_q;
  assign fsm_clr_n  = clr_n_q;

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  // Next-state logic. A bit is accepted on every RUN cycle with the
  // owner's req high; the BURST-th accepted bit ends the grant.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = win;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        if (!owner_req) begin
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear is registered from the next state so the detector sees a clean
  // low both in the cycle after reset and for the whole CLEAR cycle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= LAST_INIT;
      cnt_q   <= '0;
      clr_n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      clr_n_q <= (state_d != CLEAR);
    end
  end

  // Outputs decoded from registered state; only enable/a/hit see inputs.
  always_comb begin
    bus.grant  = '0;
    bus.hit    = '0;
    fsm_enable = 1'b0;
    fsm_a      = 1'b0;
    unique case (state_q)
      CLEAR: begin
        bus.grant = owner_onehot;
      end
      RUN: begin
        bus.grant  = owner_onehot;
        fsm_enable = owner_req;
        fsm_a      = owner_data;
        if (fsm_y) begin
          bus.hit = owner_onehot;
        end
      end
      DONE: begin
        if (fsm_y) begin
          bus.hit = owner_onehot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fsm_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fsm_stream_arbiter
// Bench for fsm_stream_arbiter with N=4, BURST=4. A small "101" Moore
// detector closes the loop on fsm_clr_n/fsm_enable/fsm_a -> fsm_y.
// -----------------------------------------------------------------------------
module tb_fsm_stream_arbiter;

  localparam int N     = 4;
  localparam int BURST = 4;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] owner;
  logic       fsm_clr_n, fsm_enable, fsm_a, fsm_y;

  fsm_stream_arbiter_if #(.N(N)) bus_if ();

  fsm_stream_arbiter #(
    .N     (N),
    .BURST (BURST)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .owner      (owner),
    .fsm_clr_n  (fsm_clr_n),
    .fsm_enable (fsm_enable),
    .fsm_a      (fsm_a),
    .fsm_y      (fsm_y)
  );

  always #5 clock = ~clock;

  // Detector: y=1 when the last three accepted bits were 1,0,1.
  logic [2:0] det_hist = '0;
  always @(posedge clock) begin
    if (fsm_clr_n !== 1'b1) det_hist <= '0;
    else if (fsm_enable === 1'b1) det_hist <= {det_hist[1:0], fsm_a};
  end
  assign fsm_y = (det_hist == 3'b101);

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Transaction-level reference: who holds the detector, whether this is the
  // first (clearing) cycle of the grant, how many bits were taken, and which
  // requester is in its post-burst attribution cycle.
  // ---------------------------------------------------------------------------
  int m_gnt   = -1;
  bit m_fresh = 0;
  int m_taken = 0;
  int m_tail  = -1;
  int m_last  = N - 1;
  int m_owner = 0;
  bit m_rst   = 0;
  bit m_valid = 0;

  always @(posedge clock) begin
    if (reset_n === 1'b0) begin
      m_gnt = -1; m_fresh = 0; m_taken = 0; m_tail = -1;
      m_last = N - 1; m_owner = 0; m_rst = 1; m_valid = 1;
    end else if (m_valid) begin
      m_rst = 0;
      if (m_tail >= 0) begin
        m_last = m_tail;
        m_tail = -1;
      end else if (m_gnt >= 0 && m_fresh) begin
        m_fresh = 0;
        m_taken = 0;
      end else if (m_gnt >= 0) begin
        if (bus_if.req[2'(m_gnt)]) begin
          m_taken++;
          if (m_taken == BURST) begin
            m_tail = m_gnt;
            m_gnt  = -1;
          end
        end else begin
          m_tail = m_gnt;
          m_gnt  = -1;
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (m_gnt < 0 && bus_if.req[2'((m_last + k) % N)]) begin
            m_gnt   = (m_last + k) % N;
            m_fresh = 1;
            m_owner = m_gnt;
          end
        end
      end
    end
  end

  logic [N-1:0] e_grant, e_hit;
  logic         e_clr, e_en, e_a;
  bit           e_strm;
  int           e_att;

  always @(negedge clock) begin
    if (m_valid) begin
      e_grant = '0; e_hit = '0; e_en = 1'b0; e_a = 1'b0;
      e_strm  = (m_gnt >= 0) && !m_fresh;
      if (m_gnt >= 0) e_grant[2'(m_gnt)] = 1'b1;
      e_clr = !(m_rst || (m_gnt >= 0 && m_fresh));
      if (e_strm) begin
        e_en = bus_if.req[2'(m_gnt)];
        e_a  = bus_if.data[2'(m_gnt)];
      end
      e_att = e_strm ? m_gnt : m_tail;
      if (e_att >= 0 && fsm_y === 1'b1) e_hit[2'(e_att)] = 1'b1;
      n_checks++;
      if ({bus_if.grant, bus_if.hit, owner, fsm_clr_n, fsm_enable, fsm_a} !==
          {e_grant, e_hit, 2'(m_owner), e_clr, e_en, e_a}) begin
        n_fail++;
        $display("FAIL model t=%0t grant=%b/%b hit=%b/%b owner=%0d/%0d clr_n=%b/%b en=%b/%b a=%b/%b (got/required)",
                 $time, bus_if.grant, e_grant, bus_if.hit, e_hit, owner, m_owner,
                 fsm_clr_n, e_clr, fsm_enable, e_en, fsm_a, e_a);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus_if.req  = '0;
    bus_if.data = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for the next grant, then counts enable cycles until the
  // grant drops. Returns at the negedge of the first grant-free cycle.
  task automatic burst_measure(output logic [N-1:0] g, output int bits);
    g = '0;
    bits = 0;
    for (int i = 0; i < 20 && g == '0; i++) begin
      @(negedge clock);
      if (bus_if.grant != '0) g = bus_if.grant;
    end
    if (g == '0) return;
    for (int i = 0; i < 20; i++) begin
      if (bus_if.grant == '0) break;
      if (fsm_enable) bits++;
      @(negedge clock);
    end
  endtask

  typedef struct packed {
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] data;
    logic [N-1:0] grant;
    logic         clr_n;
    logic         en;
    logic         a;
    logic [N-1:0] hit;
  } vec_t;

  vec_t         vt [14];
  logic [N-1:0] got_g;
  int           got_bits;
  logic [3:0]   pat;

  initial begin
    // Reset, then a lone requester 1 with bits 1,0,1,1 (non-owner data varies).
    vt[0]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[2]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    vt[3]  = '{1'b1, 4'b0010, 4'b1111, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[4]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0000};
    vt[5]  = '{1'b1, 4'b0010, 4'b1101, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000};
    vt[6]  = '{1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0000};
    vt[7]  = '{1'b1, 4'b0010, 4'b1010, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010};
    vt[8]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    vt[9]  = '{1'b1, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    vt[10] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0000};
    vt[11] = '{1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0, 4'b0000};
    vt[12] = '{1'b1, 4'b0000, 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b1, 4'b0000};
    vt[13] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};

    reset_n = 1'b0;
    bus_if.req  = '0;
    bus_if.data = '0;
    tick();
    tick();

    for (int i = 0; i < 14; i++) begin
      reset_n     = vt[i].rst_n;
      bus_if.req  = vt[i].req;
      bus_if.data = vt[i].data;
      @(negedge clock);
      n_checks++;
      if ({bus_if.grant, fsm_clr_n, fsm_enable, fsm_a, bus_if.hit} !==
          {vt[i].grant, vt[i].clr_n, vt[i].en, vt[i].a, vt[i].hit}) begin
        n_fail++;
        $display("FAIL vec%0d: grant=%b clr_n=%b en=%b a=%b hit=%b required grant=%b clr_n=%b en=%b a=%b hit=%b",
                 i, bus_if.grant, fsm_clr_n, fsm_enable, fsm_a, bus_if.hit,
                 vt[i].grant, vt[i].clr_n, vt[i].en, vt[i].a, vt[i].hit);
      end
      tick();
    end

    // Round robin with everyone requesting.
    do_reset();
    bus_if.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      burst_measure(got_g, got_bits);
      check("rr_grant", 32'(got_g), 32'(1) << (g % N));
      check("rr_bits", 32'(got_bits), 32'(BURST));
    end

    // Early release by owner 2 after two bits; requester 3 is next in order.
    do_reset();
    bus_if.req = 4'b0100;
    tick();
    @(negedge clock);
    check("er_grant", 32'(bus_if.grant), 32'h4);
    check("er_clr", 32'(fsm_clr_n), 32'h0);
    bus_if.req = 4'b1101;
    tick();
    @(negedge clock);
    check("er_en1", 32'(fsm_enable), 32'h1);
    tick();
    @(negedge clock);
    check("er_en2", 32'(fsm_enable), 32'h1);
    tick();
    bus_if.req = 4'b1001;
    @(negedge clock);
    check("er_drop_en", 32'(fsm_enable), 32'h0);
    check("er_drop_grant", 32'(bus_if.grant), 32'h4);
    tick();
    @(negedge clock);
    check("er_done_grant", 32'(bus_if.grant), 32'h0);
    burst_measure(got_g, got_bits);
    check("er_next", 32'(got_g), 32'h8);
    check("er_next_bits", 32'(got_bits), 32'(BURST));

    // Hit attribution to owner 3; other data bits random.
    do_reset();
    pat = 4'b1010;
    bus_if.req = 4'b1000;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_if.data = {pat[i], 3'($urandom)};
      @(negedge clock);
      check("hit_a", 32'(fsm_a), 32'(pat[i]));
      check("hit_quiet", 32'(bus_if.hit), 32'h0);
      tick();
    end
    @(negedge clock);
    check("hit_done", 32'(bus_if.hit), 32'h8);
    check("hit_done_grant", 32'(bus_if.grant), 32'h0);

    // Reset in the middle of owner 1's burst.
    do_reset();
    bus_if.req = 4'b0010;
    tick();
    tick();
    tick();
    reset_n = 1'b0;
    bus_if.req = 4'b1111;
    tick();
    @(negedge clock);
    check("mid_rst_grant", 32'(bus_if.grant), 32'h0);
    check("mid_rst_clr", 32'(fsm_clr_n), 32'h0);
    reset_n = 1'b1;
    burst_measure(got_g, got_bits);
    check("mid_rst_next", 32'(got_g), 32'h1);
    check("mid_rst_bits", 32'(got_bits), 32'(BURST));

    // Random traffic against the reference.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom);
      bus_if.data = 4'($urandom);
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
